// File: rtl/stream_nasti_burst_writer_if.sv
// Stream packet channel and NASTI memory channel used by the stream-to-memory
// burst writer.
interface nasti_stream_channel #(
    parameter int DATA_WIDTH = 64
);
    logic                      t_valid;
    logic                      t_ready;
    logic [DATA_WIDTH-1:0]     t_data;
    logic [DATA_WIDTH/8-1:0]   t_strb;
    logic [DATA_WIDTH/8-1:0]   t_keep;
    logic                      t_last;

    modport master (output t_valid, t_data, t_strb, t_keep, t_last, input t_ready);
    modport slave  (input t_valid, t_data, t_strb, t_keep, t_last, output t_ready);
endinterface

interface nasti_channel #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/stream_nasti_burst_writer.sv
// Stream-to-memory write engine: buffers up to one burst of packet beats, then
// writes it with a single AW/W/B exchange, repeating until the packet or limit ends.
module stream_nasti_burst_writer #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int MAX_BURST_LENGTH = 8,
    parameter int LEN_WIDTH        = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    nasti_stream_channel.slave    src,
    nasti_channel.master          dest,
    input  logic [ADDR_WIDTH-1:0] r_dest,
    input  logic [LEN_WIDTH-1:0]  r_max_beats,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic [LEN_WIDTH-1:0]  c_beats,
    output logic                  c_err,
    output logic                  c_overflow,
    output logic                  c_valid,
    input  logic                  c_ready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int FW    = $clog2(MAX_BURST_LENGTH) + 1;
    localparam int IW    = (MAX_BURST_LENGTH > 1) ? $clog2(MAX_BURST_LENGTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP, S_DRAIN, S_DONE} state_t;

    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   limit, count;
    logic                   err, ovf, last_seen;
    logic [FW-1:0]          fill, widx, cap, fill_inc;
    logic [MAX_BURST_LENGTH-1:0][DATA_WIDTH-1:0] beat_data;
    logic [MAX_BURST_LENGTH-1:0][BYTES-1:0]      beat_strb;

    logic t_ready_c, aw_valid_c, w_valid_c, b_ready_c;
    logic t_fire, keep_nz;
    logic [12:0]          to_4k;
    logic [LEN_WIDTH-1:0] remain;

    assign t_fire   = src.t_valid && t_ready_c;
    assign keep_nz  = |src.t_keep;
    assign fill_inc = fill + FW'(t_fire && keep_nz);
    assign to_4k    = (13'h1000 - {1'b0, addr[11:0]}) >> OFF;
    assign remain   = limit - count;

    // Burst size is bounded by the buffer, the next 4KB page and the beat limit.
    always_comb begin
        cap = FW'(MAX_BURST_LENGTH);
        if (to_4k < 13'(MAX_BURST_LENGTH))
            cap = to_4k[FW-1:0];
        if (limit != '0 && remain < LEN_WIDTH'(cap))
            cap = remain[FW-1:0];
    end

    always_comb begin
        state_n    = state;
        r_ready    = 1'b0;
        t_ready_c  = 1'b0;
        aw_valid_c = 1'b0;
        w_valid_c  = 1'b0;
        b_ready_c  = 1'b0;
        c_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                r_ready = 1'b1;
                if (r_valid) state_n = S_FILL;
            end
            S_FILL: begin
                t_ready_c = (fill < cap);
                if ((t_fire && src.t_last) || fill_inc == cap)
                    state_n = (fill_inc == '0) ? S_DONE : S_ADDR;
            end
            S_ADDR: begin
                aw_valid_c = 1'b1;
                if (dest.aw_ready) state_n = S_DATA;
            end
            S_DATA: begin
                w_valid_c = 1'b1;
                if (dest.w_ready && dest.w_last) state_n = S_RESP;
            end
            S_RESP: begin
                b_ready_c = 1'b1;
                if (dest.b_valid) begin
                    if (last_seen)
                        state_n = S_DONE;
                    else if (limit != '0 && count + LEN_WIDTH'(fill) == limit)
                        state_n = S_DRAIN;
                    else
                        state_n = S_FILL;
                end
            end
            S_DRAIN: begin
                t_ready_c = 1'b1;
                if (t_fire && src.t_last) state_n = S_DONE;
            end
            S_DONE: begin
                c_valid = 1'b1;
                if (c_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            addr      <= '0;
            limit     <= '0;
            count     <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            last_seen <= 1'b0;
            fill      <= '0;
            widx      <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (r_valid) begin
                    addr      <= r_dest & ~ADDR_WIDTH'(BYTES - 1);
                    limit     <= r_max_beats;
                    count     <= '0;
                    err       <= 1'b0;
                    ovf       <= 1'b0;
                    last_seen <= 1'b0;
                    fill      <= '0;
                    widx      <= '0;
                end
                S_FILL: if (t_fire) begin
                    fill <= fill_inc;
                    if (src.t_last) last_seen <= 1'b1;
                end
                S_DATA: if (dest.w_ready && !dest.w_last) widx <= widx + FW'(1);
                S_RESP: if (dest.b_valid) begin
                    err   <= err | (dest.b_resp != 2'b00);
                    count <= count + LEN_WIDTH'(fill);
                    addr  <= addr + (ADDR_WIDTH'(fill) << OFF);
                    fill  <= '0;
                    widx  <= '0;
                end
                S_DRAIN: if (t_fire && keep_nz) ovf <= 1'b1;
                default: ;
            endcase
        end
    end

    // Null beats (t_keep==0) never occupy a buffer slot.
    always_ff @(posedge aclk) begin
        if (state == S_FILL && t_fire && keep_nz) begin
            beat_data[fill[IW-1:0]] <= src.t_data;
            beat_strb[fill[IW-1:0]] <= src.t_strb & src.t_keep;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && r_valid && r_ready)
            assert ((r_dest & ADDR_WIDTH'(BYTES - 1)) == '0);
    end

    assign src.t_ready    = t_ready_c;
    assign c_beats        = count;
    assign c_err          = err;
    assign c_overflow     = ovf;

    assign dest.aw_id     = '0;
    assign dest.aw_addr   = addr;
    assign dest.aw_len    = 8'(fill - FW'(1));
    assign dest.aw_size   = 3'(OFF);
    assign dest.aw_burst  = 2'b01;
    assign dest.aw_lock   = 1'b0;
    assign dest.aw_cache  = '0;
    assign dest.aw_prot   = '0;
    assign dest.aw_qos    = '0;
    assign dest.aw_region = '0;
    assign dest.aw_user   = '0;
    assign dest.aw_valid  = aw_valid_c;

    assign dest.w_data    = beat_data[widx[IW-1:0]];
    assign dest.w_strb    = beat_strb[widx[IW-1:0]];
    assign dest.w_last    = (widx == fill - FW'(1));
    assign dest.w_user    = '0;
    assign dest.w_valid   = w_valid_c;
    assign dest.b_ready   = b_ready_c;

    assign dest.ar_id     = '0;
    assign dest.ar_addr   = '0;
    assign dest.ar_len    = '0;
    assign dest.ar_size   = '0;
    assign dest.ar_burst  = '0;
    assign dest.ar_lock   = 1'b0;
    assign dest.ar_cache  = '0;
    assign dest.ar_prot   = '0;
    assign dest.ar_qos    = '0;
    assign dest.ar_region = '0;
    assign dest.ar_user   = '0;
    assign dest.ar_valid  = 1'b0;
    assign dest.r_ready   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{dest.b_id, dest.b_user, dest.ar_ready, dest.r_id, dest.r_data,
                         dest.r_resp, dest.r_last, dest.r_user, dest.r_valid};
endmodule

// File: tb/tb_stream_nasti_burst_writer.sv
// Directed bench for stream_nasti_burst_writer: drives packets, emulates a NASTI
// write slave with optional stalls, and checks bursts and completion records.
module tb_stream_nasti_burst_writer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] r_dest = '0;
    logic [31:0] r_max_beats = '0;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [31:0] c_beats;
    logic        c_err, c_overflow, c_valid;
    logic        c_ready = 1'b0;

    nasti_stream_channel #(.DATA_WIDTH(64)) s_if();
    nasti_channel #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m_if();

    stream_nasti_burst_writer #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_BURST_LENGTH(8), .LEN_WIDTH(32)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .src(s_if), .dest(m_if),
        .r_dest(r_dest), .r_max_beats(r_max_beats), .r_valid(r_valid), .r_ready(r_ready),
        .c_beats(c_beats), .c_err(c_err), .c_overflow(c_overflow),
        .c_valid(c_valid), .c_ready(c_ready)
    );

    always #5 aclk = ~aclk;

    int nvec = 0, nfail = 0;
    bit stall = 1'b0;
    int err_burst = -1;
    int bursts_done = 0;
    int aw_seen = 0, w_bursts = 0, w_early = 0, pend_b = 0;
    bit b_fired = 1'b0;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [63:0] w_data_q[$];
    logic [7:0]  w_strb_q[$];
    logic        w_last_q[$];

    // Write slave: readies/b_valid change at negedge, fires are logged just after.
    initial begin
        m_if.aw_ready = 1'b0; m_if.w_ready = 1'b0;
        m_if.b_valid = 1'b0; m_if.b_resp = 2'b00; m_if.b_id = '0; m_if.b_user = '0;
        m_if.ar_ready = 1'b0; m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0;
        m_if.r_last = 1'b0; m_if.r_user = '0; m_if.r_valid = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_if.aw_ready = 1'b0; m_if.w_ready = 1'b0; m_if.b_valid = 1'b0;
                pend_b = 0; b_fired = 1'b0; aw_seen = 0; w_bursts = 0;
            end else begin
                if (b_fired) begin m_if.b_valid = 1'b0; b_fired = 1'b0; end
                m_if.aw_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
                m_if.w_ready  = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
                if (!m_if.b_valid && pend_b > 0 && (!stall || $urandom_range(0, 1) == 1)) begin
                    m_if.b_valid = 1'b1;
                    m_if.b_resp  = (bursts_done == err_burst) ? 2'b10 : 2'b00;
                    pend_b--;
                end
                #1;
                if (m_if.w_valid && aw_seen <= w_bursts) w_early++;
                if (m_if.aw_valid && m_if.aw_ready) begin
                    aw_addr_q.push_back(m_if.aw_addr); aw_len_q.push_back(m_if.aw_len); aw_seen++;
                end
                if (m_if.w_valid && m_if.w_ready) begin
                    w_data_q.push_back(m_if.w_data); w_strb_q.push_back(m_if.w_strb);
                    w_last_q.push_back(m_if.w_last);
                    if (m_if.w_last) begin pend_b++; w_bursts++; end
                end
                if (m_if.b_valid && m_if.b_ready) begin b_fired = 1'b1; bursts_done++; end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete();
        w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
        w_early = 0;
    endtask

    // Entered and left at a negedge; the request fires on the posedge in between.
    task automatic request(input logic [63:0] a, input logic [31:0] lim);
        r_dest = a; r_max_beats = lim; r_valid = 1'b1;
        #1;
        chk("r_ready_idle", r_ready, 1'b1);
        @(negedge aclk);
        r_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic [7:0] k,
                             input logic l);
        int n = 0;
        if (stall) repeat ($urandom_range(0, 2)) @(negedge aclk);
        s_if.t_valid = 1'b1; s_if.t_data = d; s_if.t_strb = s; s_if.t_keep = k; s_if.t_last = l;
        #1;
        while (!s_if.t_ready && n < 300) begin @(negedge aclk); #1; n++; end
        if (n >= 300) begin
            nvec++; nfail++;
            $display("FAIL beat_timeout observed=no t_ready expected=t_ready within 300 cycles");
        end
        @(negedge aclk);
        s_if.t_valid = 1'b0; s_if.t_last = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] base, input int n, input int last_at);
        for (int i = 0; i < n; i++)
            send_beat(base + 64'(i), 8'hFF, 8'hFF, (i + 1) == last_at);
    endtask

    task automatic wait_done(input logic [31:0] beats, input logic err, input logic ovf);
        int n = 0;
        #1;
        while (!c_valid && n < 1000) begin @(negedge aclk); #1; n++; end
        chk("c_valid_seen", c_valid, 1'b1);
        if (stall) begin
            repeat ($urandom_range(1, 3)) @(negedge aclk);
            #1;
            chk("c_valid_hold", c_valid, 1'b1);
        end
        chk("c_beats", c_beats, beats);
        chk("c_err", c_err, err);
        chk("c_overflow", c_overflow, ovf);
        c_ready = 1'b1;
        @(negedge aclk);
        c_ready = 1'b0;
    endtask

    initial begin
        int n;
        int cv;
        s_if.t_valid = 1'b0; s_if.t_data = '0; s_if.t_strb = '0; s_if.t_keep = '0; s_if.t_last = 1'b0;

        // Reset state and tie-offs
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_r_ready", r_ready, 1'b1);
        chk("rst_t_ready", s_if.t_ready, 1'b0);
        chk("rst_aw_valid", m_if.aw_valid, 1'b0);
        chk("rst_w_valid", m_if.w_valid, 1'b0);
        chk("rst_b_ready", m_if.b_ready, 1'b0);
        chk("rst_c_valid", c_valid, 1'b0);
        chk("rst_c_beats", c_beats, 32'd0);
        chk("aw_size", m_if.aw_size, 3'd3);
        chk("aw_burst", m_if.aw_burst, 2'b01);
        chk("ar_valid", m_if.ar_valid, 1'b0);
        chk("r_ready_tie", m_if.r_ready, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // 1: two full bursts from a page-aligned address
        clear_logs();
        request(64'h1000, 32'd0);
        send_pkt(64'h0100_0000_0000_0000, 16, 16);
        wait_done(32'd16, 1'b0, 1'b0);
        chk("t1_aw_cnt", aw_addr_q.size(), 2);
        chk("t1_aw0_addr", aw_addr_q[0], 64'h1000);
        chk("t1_aw0_len", aw_len_q[0], 8'd7);
        chk("t1_aw1_addr", aw_addr_q[1], 64'h1040);
        chk("t1_aw1_len", aw_len_q[1], 8'd7);
        chk("t1_w_cnt", w_data_q.size(), 16);
        chk("t1_w15_data", w_data_q[15], 64'h0100_0000_0000_000F);
        chk("t1_w7_last", w_last_q[7], 1'b1);
        chk("t1_w_early", w_early, 0);

        // 2: 4KB boundary split
        clear_logs();
        request(64'h1FE0, 32'd0);
        send_pkt(64'h0200_0000_0000_0000, 8, 8);
        wait_done(32'd8, 1'b0, 1'b0);
        chk("t2_aw_cnt", aw_addr_q.size(), 2);
        chk("t2_aw0_addr", aw_addr_q[0], 64'h1FE0);
        chk("t2_aw0_len", aw_len_q[0], 8'd3);
        chk("t2_aw1_addr", aw_addr_q[1], 64'h2000);
        chk("t2_aw1_len", aw_len_q[1], 8'd3);
        chk("t2_w4_data", w_data_q[4], 64'h0200_0000_0000_0004);

        // 3a: short packet with partial strobes / keep
        clear_logs();
        request(64'h3000, 32'd0);
        send_beat(64'h0300_0000_0000_0000, 8'hF0, 8'hFF, 1'b0);
        send_beat(64'h0300_0000_0000_0001, 8'hFF, 8'h0F, 1'b0);
        send_beat(64'h0300_0000_0000_0002, 8'hFF, 8'hFF, 1'b1);
        wait_done(32'd3, 1'b0, 1'b0);
        chk("t3_aw_cnt", aw_addr_q.size(), 1);
        chk("t3_aw_len", aw_len_q[0], 8'd2);
        chk("t3_w0_strb", w_strb_q[0], 8'hF0);
        chk("t3_w1_strb", w_strb_q[1], 8'h0F);
        chk("t3_w1_last", w_last_q[1], 1'b0);
        chk("t3_w2_last", w_last_q[2], 1'b1);

        // 3b: lone null beat carrying t_last
        clear_logs();
        request(64'h3100, 32'd0);
        send_beat(64'h0, 8'hFF, 8'h00, 1'b1);
        wait_done(32'd0, 1'b0, 1'b0);
        chk("t3b_aw_cnt", aw_addr_q.size(), 0);

        // 4: limit 4, 6-beat packet -> overflow
        clear_logs();
        request(64'h4000, 32'd4);
        send_pkt(64'h0400_0000_0000_0000, 6, 6);
        wait_done(32'd4, 1'b0, 1'b1);
        chk("t4_aw_cnt", aw_addr_q.size(), 1);
        chk("t4_aw_len", aw_len_q[0], 8'd3);
        chk("t4_w_cnt", w_data_q.size(), 4);

        // 4b: packet ending exactly on the limit
        clear_logs();
        request(64'h4100, 32'd4);
        send_pkt(64'h0410_0000_0000_0000, 4, 4);
        wait_done(32'd4, 1'b0, 1'b0);
        chk("t4b_aw_cnt", aw_addr_q.size(), 1);

        // 5: SLVERR on the first of two bursts
        clear_logs();
        err_burst = bursts_done;
        request(64'h5000, 32'd0);
        send_pkt(64'h0500_0000_0000_0000, 16, 16);
        wait_done(32'd16, 1'b1, 1'b0);
        err_burst = -1;
        chk("t5_aw_cnt", aw_addr_q.size(), 2);
        chk("t5_w_cnt", w_data_q.size(), 16);

        // 6: stalls, reset while in DATA, then a clean request
        stall = 1'b1;
        clear_logs();
        request(64'h6000, 32'd0);
        send_pkt(64'h0600_0000_0000_0000, 8, 0);
        n = 0;
        #1;
        while (!m_if.w_valid && n < 300) begin @(negedge aclk); #1; n++; end
        chk("t6_in_data", m_if.w_valid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_aw_valid", m_if.aw_valid, 1'b0);
        chk("t6_rst_w_valid", m_if.w_valid, 1'b0);
        chk("t6_rst_b_ready", m_if.b_ready, 1'b0);
        chk("t6_rst_r_ready", r_ready, 1'b1);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        cv = 0;
        repeat (10) begin @(negedge aclk); #1; if (c_valid) cv++; end
        chk("t6_no_c_valid", cv, 0);
        @(negedge aclk);
        clear_logs();
        request(64'h6000, 32'd0);
        send_pkt(64'h0610_0000_0000_0000, 5, 5);
        wait_done(32'd5, 1'b0, 1'b0);
        chk("t6_aw_cnt", aw_addr_q.size(), 1);
        chk("t6_aw_len", aw_len_q[0], 8'd4);
        chk("t6_w4_data", w_data_q[4], 64'h0610_0000_0000_0004);
        chk("t6_w_early", w_early, 0);
        stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
